// File: rtl/core_mem_responder_if.sv
// Request/response bus between a requester (master) and the memory responder (slave).
// Signal suffixes are named from the responder's point of view.
interface core_mem_responder_if;
    logic [31:0] inport_addr_i;
    logic [31:0] inport_write_data_i;
    logic [3:0]  inport_wr_i;
    logic        inport_rd_i;
    logic        inport_accept_o;
    logic        inport_ack_o;
    logic        inport_error_o;
    logic [31:0] inport_read_data_o;

    modport master (
        output inport_addr_i, inport_write_data_i, inport_wr_i, inport_rd_i,
        input  inport_accept_o, inport_ack_o, inport_error_o, inport_read_data_o
    );

    modport slave (
        input  inport_addr_i, inport_write_data_i, inport_wr_i, inport_rd_i,
        output inport_accept_o, inport_ack_o, inport_error_o, inport_read_data_o
    );
endinterface

// File: rtl/core_mem_responder.sv
// Single-outstanding memory responder with byte-enabled writes, configurable read latency
// and optional emulated refresh stalls.
module core_mem_responder #(
    parameter int MEM_AW         = 10,
    parameter int READ_LATENCY   = 2,
    parameter int REFRESH_PERIOD = 0,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    core_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP, REFRESH} state_t;

    localparam int          RP       = (REFRESH_PERIOD > 0) ? REFRESH_PERIOD : 1;
    localparam logic [2:0]  LAT_INIT = 3'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);
    localparam logic [3:0]  RC_INIT  = 4'(REFRESH_CYCLES - 1);

    state_t      state_q, state_d;
    logic        accept_q, accept_d;
    logic        ack_q, ack_d;
    logic        error_q, error_d;
    logic        data_vld_q, data_vld_d;
    logic        due_q, due_d;
    logic [2:0]  lat_q, lat_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [31:0] ref_cnt_q, ref_cnt_d;

    logic [31:0] mem [0:(1 << MEM_AW) - 1];
    logic [31:0] mem_rd_q;

    logic [MEM_AW-1:0] word_idx;
    logic req, take, bad, refresh_hit, due_pending, mem_we, mem_re;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^bus.inport_addr_i[1:0];
    assign word_idx        = bus.inport_addr_i[MEM_AW+1:2];
    assign req             = bus.inport_rd_i || (bus.inport_wr_i != 4'd0);
    // Accept is a registered decision; reset only masks it so nothing is taken during reset.
    assign take            = accept_q && rst_ni && req;
    assign bad             = (|bus.inport_addr_i[31:MEM_AW+2]) ||
                             (bus.inport_rd_i && (bus.inport_wr_i != 4'd0));
    assign mem_we          = take && !bad && (bus.inport_wr_i != 4'd0);
    assign mem_re          = take && !bad && bus.inport_rd_i;

    always_comb begin
        ref_cnt_d   = ref_cnt_q;
        refresh_hit = 1'b0;
        if (REFRESH_PERIOD > 0) begin
            refresh_hit = (ref_cnt_q == 32'(RP - 1));
            ref_cnt_d   = refresh_hit ? 32'd0 : ref_cnt_q + 32'd1;
        end
        // A newly reached refresh point is pending immediately, so an idle or finishing
        // responder can go straight into the stall without an extra dead cycle.
        due_pending = due_q || refresh_hit;

        state_d    = state_q;
        due_d      = due_pending;
        lat_d      = lat_q;
        rcnt_d     = rcnt_q;
        ack_d      = 1'b0;
        error_d    = 1'b0;
        data_vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (take) begin
                    if (bad || !bus.inport_rd_i) begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        error_d = bad;
                    end else if (READ_LATENCY <= 1) begin
                        state_d    = RESP;
                        ack_d      = 1'b1;
                        data_vld_d = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        lat_d   = LAT_INIT;
                    end
                end else if (due_pending) begin
                    state_d = REFRESH;
                    rcnt_d  = RC_INIT;
                    due_d   = 1'b0;
                end
            end
            RD_WAIT: begin
                if (lat_q == 3'd0) begin
                    state_d    = RESP;
                    ack_d      = 1'b1;
                    data_vld_d = 1'b1;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RESP: begin
                if (due_pending) begin
                    state_d = REFRESH;
                    rcnt_d  = RC_INIT;
                    due_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            REFRESH: begin
                if (rcnt_q != 4'd0) begin
                    rcnt_d = rcnt_q - 4'd1;
                end else if (due_pending) begin
                    rcnt_d = RC_INIT;
                    due_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        accept_d = (state_d == IDLE) && !due_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            accept_q   <= 1'b0;
            ack_q      <= 1'b0;
            error_q    <= 1'b0;
            data_vld_q <= 1'b0;
            due_q      <= 1'b0;
            lat_q      <= 3'd0;
            rcnt_q     <= 4'd0;
            ref_cnt_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            accept_q   <= accept_d;
            ack_q      <= ack_d;
            error_q    <= error_d;
            data_vld_q <= data_vld_d;
            due_q      <= due_d;
            lat_q      <= lat_d;
            rcnt_q     <= rcnt_d;
            ref_cnt_q  <= ref_cnt_d;
        end
    end

    // Memory contents deliberately survive reset; read port captures the word at accept.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.inport_wr_i[b]) begin
                    mem[word_idx][b*8 +: 8] <= bus.inport_write_data_i[b*8 +: 8];
                end
            end
        end
        if (mem_re) begin
            mem_rd_q <= mem[word_idx];
        end
    end

    assign bus.inport_accept_o    = accept_q && rst_ni;
    assign bus.inport_ack_o       = ack_q;
    assign bus.inport_error_o     = error_q;
    assign bus.inport_read_data_o = data_vld_q ? mem_rd_q : 32'd0;
endmodule
